// File: rtl/serial_shift_out_if.sv
// Pin-side bundle of the serial shift-register driver: request/data inputs
// and the 74HC595-style chain outputs plus the busy/done handshake.
interface serial_shift_out_if #(
  parameter int unsigned DATA_W = 16
);
  logic              en;
  logic              start;
  logic [DATA_W-1:0] p_data;
  logic              sclk;
  logic              sout;
  logic              sen;
  logic              sclrn;
  logic              busy;
  logic              done;

  modport master (
    output en, start, p_data,
    input  sclk, sout, sen, sclrn, busy, done
  );

  modport slave (
    input  en, start, p_data,
    output sclk, sout, sen, sclrn, busy, done
  );
endinterface

// File: rtl/serial_shift_out.sv
// Serialises a parallel frame onto a shift-register chain (sclk/sout), pulses
// the latch enable afterwards, and reports busy/done; all outputs registered.
module serial_shift_out #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned DIV_HALF     = 4,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter bit          INVERT_SOUT  = 1'b0,
  parameter bit          AUTO_REFRESH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  serial_shift_out_if.slave bus
);
  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam int unsigned      DIV_W    = $clog2(DIV_HALF + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic              r_phase, w_phase_nxt;
  logic              r_from_done;
  logic              r_sclk, r_sout, r_sen, r_sclrn, r_busy, r_done;
  logic              w_go, w_head, w_div_last;
  logic [DATA_W-1:0] w_shifted;

  // An auto-refresh restart is only possible in the IDLE cycle right after DONE.
  assign w_go       = bus.en & (bus.start | (AUTO_REFRESH & r_from_done));
  assign w_head     = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
  assign w_shifted  = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
  assign w_div_last = (r_div == DIV_LAST);

  // Next-state logic; r_phase selects the low (0) or high (1) half of a bit.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_phase_nxt = r_phase;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_shift_nxt = bus.p_data;
          w_cnt_nxt   = CNT_FULL;
          w_div_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_div_last) begin
          w_div_nxt = '0;
          if (r_phase) begin
            w_phase_nxt = 1'b0;
            w_shift_nxt = w_shifted;
            w_cnt_nxt   = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              w_state_nxt = S_LATCH;
            end else begin
              w_state_nxt = S_SHIFT;
            end
          end else begin
            w_phase_nxt = 1'b1;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_LATCH: begin
        if (w_div_last) begin
          w_div_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and pin registers; pins lag the state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_div       <= '0;
      r_phase     <= 1'b0;
      r_from_done <= 1'b0;
      r_sclk      <= 1'b0;
      r_sout      <= INVERT_SOUT;
      r_sen       <= 1'b0;
      r_sclrn     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div       <= w_div_nxt;
      r_phase     <= w_phase_nxt;
      r_from_done <= (r_state == S_DONE);
      r_sclk      <= (r_state == S_SHIFT) && r_phase;
      r_sen       <= (r_state == S_LATCH);
      r_sclrn     <= 1'b1;
      r_busy      <= (r_state == S_SHIFT) || (r_state == S_LATCH);
      r_done      <= (r_state == S_DONE);
      if (r_state == S_SHIFT) begin
        r_sout <= w_head ^ INVERT_SOUT;
      end else begin
        r_sout <= r_sout;
      end
    end
  end

  assign bus.sclk  = r_sclk;
  assign bus.sout  = r_sout;
  assign bus.sen   = r_sen;
  assign bus.sclrn = r_sclrn;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule
